// File: rtl/io_pkg.sv
// Shared types for the core I/O path.
// Read FSM states and default RX FIFO depth.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    ACK
  } rd_state_t;

  localparam int IO_FIFO_DEPTH_LOG2 = 11;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with asynchronous read port.
// Pointers wrap naturally at the power-of-two depth.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [7:0]            wdata,
  input  logic                  pop,
  output logic [7:0]            rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + DEPTH_LOG2'(1);
      if (pop)  rptr <= rptr + DEPTH_LOG2'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: byte FIFO plus a byte/word read FSM.
// Words are big-endian: first received byte in [31:24].
module uart_rx_buffer
  import io_pkg::*;
#(
  parameter int DEPTH_LOG2 = IO_FIFO_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                rx_ferr,
  input  logic                rd_req,
  input  logic                rd_word,
  output logic [31:0]         rd_data,
  output logic                rd_ack,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic [7:0]          ferr_cnt
);

  localparam int CW = DEPTH_LOG2 + 1;

  rd_state_t   state;
  logic        word_q;
  logic [1:0]  pop_cnt;
  logic [23:0] acc;
  logic [31:0] acc_nxt;
  logic [1:0]  pop_last;
  logic [CW-1:0] need_now;

  logic        f_push;
  logic        f_pop;
  logic [7:0]  f_rdata;
  logic        f_full;
  logic        f_empty;

  assign f_push   = rx_valid & ~rx_ferr & ~f_full;
  assign f_pop    = (state == POP) & ~f_empty;
  assign acc_nxt  = {acc, f_rdata};
  assign pop_last = word_q ? 2'd3 : 2'd0;
  assign need_now = rd_word ? CW'(4) : CW'(1);

  byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (f_push),
    .wdata (rx_data),
    .pop   (f_pop),
    .rdata (f_rdata),
    .count (count),
    .full  (f_full),
    .empty (f_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
      ferr_cnt <= '0;
    end else if (rx_valid) begin
      if (rx_ferr) begin
        if (ferr_cnt != 8'hff) ferr_cnt <= ferr_cnt + 8'd1;
      end else if (f_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Admission uses registered count, so a pop never races a same-cycle push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      word_q  <= 1'b0;
      pop_cnt <= '0;
      acc     <= '0;
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd_req) begin
            word_q <= rd_word;
            if (count >= need_now) begin
              state   <= POP;
              pop_cnt <= '0;
            end
          end
        end
        POP: begin
          acc     <= acc_nxt[23:0];
          pop_cnt <= pop_cnt + 2'd1;
          if (pop_cnt == pop_last) begin
            state   <= ACK;
            rd_ack  <= 1'b1;
            rd_data <= word_q ? acc_nxt
                              : {24'b0, f_rdata};
          end
        end
        ACK: begin
          state   <= IDLE;
          rd_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
